// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline boundary registers of the 8-bit core.
// Includes control-bit positions and the widths used at each stage boundary.
package pipe_pkg;

    // EX group of the control bundle
    localparam int ALUSRC     = 0;
    localparam int ALUOP0     = 1;
    localparam int ALUOP1     = 2;
    localparam int REGDST     = 3;
    // M group
    localparam int MEMWRITE   = 0;
    localparam int MEMREAD    = 1;
    localparam int BRANCHFLIP = 2;
    localparam int BRANCH     = 3;
    // WB group
    localparam int REGWRITE   = 0;
    localparam int MEMTOREG   = 1;

    typedef enum logic [1:0] {
        BND_IF_ID,
        BND_ID_EX,
        BND_EX_MEM,
        BND_MEM_WB
    } boundary_e;

    localparam int IF_ID_CTRL_W  = 1;
    localparam int IF_ID_DATA_W  = 24;
    localparam int ID_EX_CTRL_W  = 10;
    localparam int ID_EX_DATA_W  = 90;
    localparam int EX_MEM_CTRL_W = 6;
    localparam int EX_MEM_DATA_W = 28;
    localparam int MEM_WB_CTRL_W = 2;
    localparam int MEM_WB_DATA_W = 19;

    function automatic int ctrl_width(input boundary_e b);
        case (b)
            BND_IF_ID:  return IF_ID_CTRL_W;
            BND_ID_EX:  return ID_EX_CTRL_W;
            BND_EX_MEM: return EX_MEM_CTRL_W;
            default:    return MEM_WB_CTRL_W;
        endcase
    endfunction

    function automatic int data_width(input boundary_e b);
        case (b)
            BND_IF_ID:  return IF_ID_DATA_W;
            BND_ID_EX:  return ID_EX_DATA_W;
            BND_EX_MEM: return EX_MEM_DATA_W;
            default:    return MEM_WB_DATA_W;
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// One holding slot: valid flag, control bundle and payload with load/clear.
// Clear zeroes the control bits (bubble) but leaves the payload untouched.
module pipe_skid_entry
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 10,
    parameter int DATA_W = 90
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, stall, flush and
// an optional skid slot that makes in_ready a registered signal.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 10,
    parameter int DATA_W = 90,
    parameter int SKID   = 0,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              w_accept;
    logic              w_release;
    logic              w_main_load;
    logic              w_main_clear;
    logic [CTRL_W-1:0] w_main_ctrl_in;
    logic [DATA_W-1:0] w_main_data_in;
    logic [CNT_W-1:0]  r_bubble_cnt;

    assign w_accept  = in_valid & in_ready;
    assign w_release = out_valid & out_ready & ~stall;

    generate
        if (SKID == 0) begin : g_single
            assign in_ready       = ~stall & ~flush & (~out_valid | out_ready);
            assign w_main_load    = w_accept;
            assign w_main_clear   = flush | (w_release & ~w_accept);
            assign w_main_ctrl_in = in_ctrl;
            assign w_main_data_in = in_data;
        end else begin : g_skid
            logic              w_skid_valid;
            logic [CTRL_W-1:0] w_skid_ctrl;
            logic [DATA_W-1:0] w_skid_data;
            logic              w_skid_load;
            logic              w_skid_clear;
            logic              w_skid_to_main;
            logic              w_skid_valid_next;
            logic              r_in_ready;

            // in_ready is low whenever the skid slot is occupied, so an accept
            // never coincides with a skid-to-main transfer.
            assign w_skid_to_main = w_release & w_skid_valid;
            assign w_main_load    = w_skid_to_main | (w_accept & (~out_valid | w_release));
            assign w_main_clear   = flush | (w_release & ~w_skid_valid & ~w_accept);
            assign w_skid_load    = w_accept & out_valid & ~w_release;
            assign w_skid_clear   = flush | w_skid_to_main;
            assign w_main_ctrl_in = w_skid_to_main ? w_skid_ctrl : in_ctrl;
            assign w_main_data_in = w_skid_to_main ? w_skid_data : in_data;

            always_comb begin
                w_skid_valid_next = w_skid_valid;
                if (w_skid_clear) begin
                    w_skid_valid_next = 1'b0;
                end else if (w_skid_load) begin
                    w_skid_valid_next = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_in_ready <= 1'b0;
                end else begin
                    r_in_ready <= ~w_skid_valid_next;
                end
            end

            assign in_ready = r_in_ready & ~stall & ~flush;

            pipe_skid_entry #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_skid (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_skid_load),
                .i_clear (w_skid_clear),
                .i_ctrl  (in_ctrl),
                .i_data  (in_data),
                .o_valid (w_skid_valid),
                .o_ctrl  (w_skid_ctrl),
                .o_data  (w_skid_data)
            );
        end
    endgenerate

    pipe_skid_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_ctrl  (w_main_ctrl_in),
        .i_data  (w_main_data_in),
        .o_valid (out_valid),
        .o_ctrl  (out_ctrl),
        .o_data  (out_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (!out_valid && (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (plain, skid, 4-bit counter) share
// one stimulus; a FIFO-level model predicts every output each cycle.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [9:0]  in_ctrl = '0;
    logic [89:0] in_data = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        v0, v1, v2, r0, r1, r2;
    logic [9:0]  c0, c1, c2;
    logic [89:0] d0, d1, d2;
    logic [15:0] n0, n1;
    logic [3:0]  n2;

    logic         a_v [3];
    logic         a_r [3];
    logic [127:0] a_ctrl [3];
    logic [127:0] a_data [3];
    logic [127:0] a_cnt [3];

    int n_tests = 0;
    int n_fail  = 0;

    // model state: per instance, number of held beats and their contents in order
    int          m_n [3];
    logic [9:0]  m_ctrl [3][2];
    logic [89:0] m_data [3][2];
    int          m_bub [3];
    bit          m_started = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(10), .DATA_W(90), .SKID(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r0), .in_ctrl(in_ctrl),
        .in_data(in_data), .stall(stall), .flush(flush), .out_valid(v0), .out_ready(out_ready),
        .out_ctrl(c0), .out_data(d0), .bubble_cnt(n0));
    pipe_stage_reg #(.CTRL_W(10), .DATA_W(90), .SKID(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1), .in_ctrl(in_ctrl),
        .in_data(in_data), .stall(stall), .flush(flush), .out_valid(v1), .out_ready(out_ready),
        .out_ctrl(c1), .out_data(d1), .bubble_cnt(n1));
    pipe_stage_reg #(.CTRL_W(10), .DATA_W(90), .SKID(0), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r2), .in_ctrl(in_ctrl),
        .in_data(in_data), .stall(stall), .flush(flush), .out_valid(v2), .out_ready(out_ready),
        .out_ctrl(c2), .out_data(d2), .bubble_cnt(n2));

    assign a_v[0] = v0;  assign a_v[1] = v1;  assign a_v[2] = v2;
    assign a_r[0] = r0;  assign a_r[1] = r1;  assign a_r[2] = r2;
    assign a_ctrl[0] = {118'b0, c0};  assign a_ctrl[1] = {118'b0, c1};  assign a_ctrl[2] = {118'b0, c2};
    assign a_data[0] = {38'b0, d0};   assign a_data[1] = {38'b0, d1};   assign a_data[2] = {38'b0, d2};
    assign a_cnt[0] = {112'b0, n0};   assign a_cnt[1] = {112'b0, n1};   assign a_cnt[2] = {124'b0, n2};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int cnt_max(input int i);
        return (i == 2) ? 15 : 65535;
    endfunction

    // Plain instances take a beat when empty or when the held one leaves;
    // the skid instance takes one whenever fewer than two are held.
    function automatic bit exp_ready(input int i);
        if (stall || flush) return 1'b0;
        if (i == 1) return m_started && (m_n[i] < 2);
        return (m_n[i] == 0) || out_ready;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 3; i++) begin
                    m_n[i]   = 0;
                    m_bub[i] = 0;
                end
                m_started = 1'b0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    bit rdy;
                    bit rel;
                    bit acc;
                    rdy = exp_ready(i);
                    if (m_n[i] == 0 && m_bub[i] < cnt_max(i)) m_bub[i]++;
                    if (flush) begin
                        m_n[i] = 0;
                    end else if (!stall) begin
                        rel = (m_n[i] > 0) && out_ready;
                        acc = in_valid && rdy;
                        if (rel) begin
                            m_ctrl[i][0] = m_ctrl[i][1];
                            m_data[i][0] = m_data[i][1];
                            m_n[i]--;
                        end
                        if (acc) begin
                            m_ctrl[i][m_n[i]] = in_ctrl;
                            m_data[i][m_n[i]] = in_data;
                            m_n[i]++;
                        end
                    end
                end
                m_started = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                bit ev;
                ev = (m_n[i] > 0);
                chk($sformatf("dut%0d out_valid", i), {127'b0, a_v[i]}, {127'b0, ev});
                chk($sformatf("dut%0d out_ctrl", i), a_ctrl[i], ev ? {118'b0, m_ctrl[i][0]} : 128'd0);
                if (ev) chk($sformatf("dut%0d out_data", i), a_data[i], {38'b0, m_data[i][0]});
                chk($sformatf("dut%0d bubble_cnt", i), a_cnt[i], 128'(m_bub[i]));
                chk($sformatf("dut%0d in_ready", i), {127'b0, a_r[i]}, {127'b0, exp_ready(i)});
            end
        end
    end

    task automatic step(input bit v, input logic [89:0] d, input logic [9:0] c,
                        input bit ordy, input bit st, input bit fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset dut%0d valid", i), {127'b0, a_v[i]}, 128'd0);
            chk($sformatf("reset dut%0d ctrl", i), a_ctrl[i], 128'd0);
            chk($sformatf("reset dut%0d data", i), a_data[i], 128'd0);
            chk($sformatf("reset dut%0d cnt", i), a_cnt[i], 128'd0);
        end
        chk("reset skid in_ready", {127'b0, r1}, 128'd0);
        #10 rst_n = 1'b1;

        // stream of four beats, back to back
        step(1'b1, 90'h11, 10'h3FF, 1'b1, 1'b0, 1'b0);
        chk("stream first valid", {127'b0, v0}, 128'd1);
        chk("stream first data", a_data[0], 128'h11);
        chk("stream first ctrl", a_ctrl[0], 128'h3FF);
        chk("stream first cnt", a_cnt[0], 128'd1);
        step(1'b1, 90'h22, 10'h3FF, 1'b1, 1'b0, 1'b0);
        chk("stream second data", a_data[0], 128'h22);
        step(1'b1, 90'h33, 10'h3FF, 1'b1, 1'b0, 1'b0);
        chk("stream third data", a_data[0], 128'h33);
        step(1'b1, 90'h44, 10'h3FF, 1'b1, 1'b0, 1'b0);
        chk("stream fourth data", a_data[0], 128'h44);
        chk("stream fourth valid", {127'b0, v0}, 128'd1);
        step(1'b0, 90'h0, 10'h0, 1'b1, 1'b0, 1'b0);
        chk("stream end valid", {127'b0, v0}, 128'd0);
        chk("stream end ctrl", a_ctrl[0], 128'd0);
        chk("stream end cnt", a_cnt[0], 128'd1);
        chk("skid stream cnt", a_cnt[1], 128'd2);
        step(1'b0, 90'h0, 10'h0, 1'b1, 1'b0, 1'b0);

        // skid fill with downstream blocked, then drain
        step(1'b1, 90'h11, 10'h155, 1'b0, 1'b0, 1'b0);
        step(1'b1, 90'h22, 10'h0AA, 1'b0, 1'b0, 1'b0);
        chk("skid full in_ready", {127'b0, r1}, 128'd0);
        chk("skid full main data", a_data[1], 128'h11);
        step(1'b1, 90'h33, 10'h0F0, 1'b0, 1'b0, 1'b0);
        chk("skid hold in_ready", {127'b0, r1}, 128'd0);
        chk("skid hold main data", a_data[1], 128'h11);
        step(1'b0, 90'h0, 10'h0, 1'b1, 1'b0, 1'b0);
        chk("skid drain data", a_data[1], 128'h22);
        chk("skid drain ctrl", a_ctrl[1], 128'h0AA);
        chk("skid drain in_ready", {127'b0, r1}, 128'd1);
        step(1'b0, 90'h0, 10'h0, 1'b1, 1'b0, 1'b0);
        chk("skid drained valid", {127'b0, v1}, 128'd0);

        // stall holds a valid beat
        step(1'b1, 90'h55, 10'h1C3, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 90'h77, 10'h111, 1'b1, 1'b1, 1'b0);
            chk("stall data", a_data[0], 128'h55);
            chk("stall valid", {127'b0, v0}, 128'd1);
            chk("stall in_ready", {127'b0, r0}, 128'd0);
        end
        step(1'b0, 90'h0, 10'h0, 1'b1, 1'b0, 1'b0);
        chk("stall release valid", {127'b0, v0}, 128'd0);

        // flush with main and skid full plus an incoming beat
        step(1'b1, 90'h55, 10'h2B4, 1'b0, 1'b0, 1'b0);
        step(1'b1, 90'h5A, 10'h0C3, 1'b0, 1'b0, 1'b0);
        chk("pre-flush skid in_ready", {127'b0, r1}, 128'd0);
        step(1'b1, 90'h66, 10'h3C3, 1'b0, 1'b0, 1'b1);
        chk("flush skid valid", {127'b0, v1}, 128'd0);
        chk("flush skid ctrl", a_ctrl[1], 128'd0);
        chk("flush plain valid", {127'b0, v0}, 128'd0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 90'h0, 10'h0, 1'b1, 1'b0, 1'b0);
            chk("post-flush valid", {127'b0, v1}, 128'd0);
            chk("post-flush in_ready", {127'b0, r1}, 128'd1);
        end

        // asynchronous reset with two beats held in the skid instance
        step(1'b1, 90'h81, 10'h201, 1'b0, 1'b0, 1'b0);
        step(1'b1, 90'h82, 10'h202, 1'b0, 1'b0, 1'b0);
        chk("pre-reset skid valid", {127'b0, v1}, 128'd1);
        chk("pre-reset skid in_ready", {127'b0, r1}, 128'd0);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("async reset dut%0d valid", i), {127'b0, a_v[i]}, 128'd0);
            chk($sformatf("async reset dut%0d ctrl", i), a_ctrl[i], 128'd0);
            chk($sformatf("async reset dut%0d cnt", i), a_cnt[i], 128'd0);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;

        // idle: the 4-bit counter saturates at 15
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 90'h0, 10'h0, 1'b1, 1'b0, 1'b0);
            chk("sat cnt4", a_cnt[2], (k < 15) ? 128'(k) : 128'd15);
        end
        chk("idle cnt16", a_cnt[0], 128'd20);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
